rs_enc_255_239: RTL

- Systematic RS(255,239) encoder over GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02.
- Generator g(x) = prod_{i=1..16} (x + alpha^i), the same roots alpha^1..alpha^16 that the decoder syndrome stage evaluates.
- Accepts message symbols on a valid/ready stream, passes them through, then emits 16 parity symbols from a 16-stage LFSR.
- Sits at the transmit end of the RS datapath; its codewords feed the decoder unchanged.

---
 rtl/rs_enc_255_239.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rs_enc_255_239.sv
// Systematic RS(255,239) encoder over GF(2^8) (poly 0x11D), generator roots alpha^1..alpha^16.
// Message symbols pass straight through; the 16-symbol LFSR remainder follows as parity.
module rs_enc_255_239 #(
  parameter int MSG_LEN = 239,
  parameter int PAR_LEN = 16
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sop,
  output logic       out_eop,
  output logic       out_par
);

  if (PAR_LEN != 16) begin : g_bad_par_len
    $error("rs_enc_255_239: PAR_LEN must be 16");
  end
  if (MSG_LEN < 1 || MSG_LEN > 239) begin : g_bad_msg_len
    $error("rs_enc_255_239: MSG_LEN must be in 1..239");
  end

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

  // With one operand constant this reduces to a fixed XOR network.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] aa;
    r  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ aa;
      aa = xtime(aa);
    end
    return r;
  endfunction

  // g0..g15 packed low to high; the monic x^16 term is implicit.
  function automatic logic [127:0] gen_poly();
    logic [135:0] g;
    logic [7:0]   root;
    g       = '0;
    g[7:0]  = 8'h01;
    root    = 8'h01;
    for (int i = 1; i <= 16; i++) begin
      root = xtime(root);
      for (int k = 16; k >= 1; k--)
        g[8*k +: 8] = g[8*(k-1) +: 8] ^ gf_mul(root, g[8*k +: 8]);
      g[7:0] = gf_mul(root, g[7:0]);
    end
    return g[127:0];
  endfunction

  localparam logic [127:0] G_COEF = gen_poly();

  // state   | meaning
  // ST_MSG  | accepting message symbols, LFSR absorbs each one
  // ST_PAR  | shifting the 16 parity symbols out, input blocked
  typedef enum logic {ST_MSG = 1'b0, ST_PAR = 1'b1} state_t;

  state_t     state_q;
  logic [7:0] sym_cnt_q;
  logic [3:0] par_cnt_q;
  logic [7:0] p_q [16];
  logic [7:0] p_d [16];
  logic [7:0] fb;
  logic       out_valid_q, out_sop_q, out_eop_q, out_par_q;
  logic [7:0] out_data_q;
  logic       stage_free;
  logic       accept;

  assign stage_free = !out_valid_q || out_ready;
  assign in_ready   = (state_q == ST_MSG) && stage_free;
  assign accept     = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_par   = out_par_q;

  always_comb begin
    fb     = in_data ^ p_q[15];
    p_d[0] = gf_mul(G_COEF[7:0], fb);
    for (int i = 1; i < 16; i++)
      p_d[i] = p_q[i-1] ^ gf_mul(G_COEF[8*i +: 8], fb);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_MSG;
      sym_cnt_q   <= '0;
      par_cnt_q   <= '0;
      for (int i = 0; i < 16; i++) p_q[i] <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_par_q   <= 1'b0;
    end else if (clear) begin
      state_q     <= ST_MSG;
      sym_cnt_q   <= '0;
      par_cnt_q   <= '0;
      for (int i = 0; i < 16; i++) p_q[i] <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_par_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_MSG: begin
          if (accept) begin
            out_data_q  <= in_data;
            out_valid_q <= 1'b1;
            out_par_q   <= 1'b0;
            out_sop_q   <= (sym_cnt_q == 8'd0);
            out_eop_q   <= 1'b0;
            for (int i = 0; i < 16; i++) p_q[i] <= p_d[i];
            if (sym_cnt_q == 8'(MSG_LEN - 1)) begin
              state_q   <= ST_PAR;
              sym_cnt_q <= '0;
              par_cnt_q <= '0;
            end else begin
              sym_cnt_q <= sym_cnt_q + 8'd1;
            end
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        ST_PAR: begin
          // A stalled output stage freezes the LFSR along with the data.
          if (stage_free) begin
            out_data_q  <= p_q[15];
            out_valid_q <= 1'b1;
            out_par_q   <= 1'b1;
            out_sop_q   <= 1'b0;
            out_eop_q   <= (par_cnt_q == 4'd15);
            p_q[0]      <= '0;
            for (int i = 1; i < 16; i++) p_q[i] <= p_q[i-1];
            par_cnt_q   <= par_cnt_q + 4'd1;
            if (par_cnt_q == 4'd15) state_q <= ST_MSG;
          end
        end
      endcase
    end
  end

endmodule
